traffic_source_gen: RTL

TRAFFIC_SOURCE_GEN -- requirements
Module: traffic_source_gen

---
 rtl/traffic_source_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/traffic_source_gen.sv
// traffic_source_gen: packet injector for a network-on-chip source node.
// Picks a destination from a constant table (sequentially, at random, or
// always entry 0), gates injection with an LFSR-based rate threshold, and
// emits one-cycle req pulses carrying {payload, dest}. Every issue is
// followed by a one-cycle pause.
module traffic_source_gen #(
   parameter int unsigned ID           = 0,
   parameter int unsigned DESTS        = 4,
   parameter int unsigned ADDR_BITS    = 4,
   parameter int unsigned PAYLOAD_SIZE = 8,
   parameter int unsigned PIR          = 256,
   parameter int unsigned MODE         = 0,
   parameter int unsigned REPEAT       = 1,
   parameter int unsigned MAX_PKTS     = 0,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter              TRAFFIC_FILE = "",
   // Destination table contents; entry i sits at [i*ADDR_BITS +: ADDR_BITS].
   parameter logic [DESTS*ADDR_BITS-1:0] DEST_TABLE = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              send,
   input  logic                              busy,
   output logic                              req,
   output logic [PAYLOAD_SIZE+ADDR_BITS-1:0] data,
   output logic                              done,
   output logic [15:0]                       pkt_count
);

   localparam int unsigned IDX_W  = (DESTS > 1) ? $clog2(DESTS) : 1;
   localparam int unsigned DATA_W = PAYLOAD_SIZE + ADDR_BITS;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            lfsr_q, lfsr_nxt;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       cand_idx;
   logic [ADDR_BITS-1:0]   cand;
   logic [ADDR_BITS-1:0]   dest_tbl [DESTS];
   logic                   req_d;
   logic [DATA_W-1:0]      data_d;
   logic [15:0]            cnt_d;
   logic                   stop_q, stop_d;
   logic                   fire;
   logic                   eligible;
   logic                   is_self;
   logic                   last_entry;
   logic                   max_hit;

   // Unpack the flat table parameter into addressable entries.
   for (genvar g = 0; g < DESTS; g++) begin : g_tbl
      assign dest_tbl[g] = DEST_TABLE[g*ADDR_BITS +: ADDR_BITS];
   end

   assign lfsr_nxt   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
   assign fire       = (PIR >= 256) || (32'(lfsr_q[7:0]) < PIR);
   assign eligible   = (state_q == RUN) && send && !busy;
   assign last_entry = (idx_q == IDX_W'(DESTS - 1));
   assign max_hit    = (MAX_PKTS != 0) && (32'(pkt_count) >= MAX_PKTS);
   assign cand       = dest_tbl[cand_idx];
   assign is_self    = (cand == ADDR_BITS'(ID));
   assign done       = (state_q == DONE);

   // Candidate table index for the selected traffic pattern.
   always_comb begin
      cand_idx = idx_q;
      if (MODE == 1) begin
         cand_idx = IDX_W'(32'(lfsr_q[15:8]) % DESTS);
      end else if (MODE == 2) begin
         cand_idx = '0;
      end
   end

   // Next-state, issue and index update logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      req_d   = 1'b0;
      data_d  = data;
      cnt_d   = pkt_count;
      stop_d  = stop_q;
      case (state_q)
         RUN: begin
            if (eligible && fire) begin
               if (!is_self) begin
                  req_d   = 1'b1;
                  data_d  = {PAYLOAD_SIZE'(ID), cand};
                  cnt_d   = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;
                  state_d = PAUSE;
               end
               if (MODE == 0) begin
                  if (last_entry) begin
                     idx_d = '0;
                     // Non-repeating wrap: stop now if nothing was issued,
                     // otherwise let the issued packet take its pause first.
                     if (REPEAT == 0) begin
                        if (is_self) state_d = DONE;
                        else         stop_d  = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         end
         PAUSE: begin
            state_d = (stop_q || max_hit) ? DONE : RUN;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State, LFSR and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         lfsr_q    <= SEED;
         idx_q     <= '0;
         req       <= 1'b0;
         data      <= '0;
         pkt_count <= '0;
         stop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_nxt;
         idx_q     <= idx_d;
         req       <= req_d;
         data      <= data_d;
         pkt_count <= cnt_d;
         stop_q    <= stop_d;
      end
   end

endmodule
